branch_tag_ctrl: RTL and testbench
==================================

Name: branch_tag_ctrl

Overview:
- Owns the branch-tag namespace used by the branch file and all reservation stations.
- Allocates one-hot branch tags to new branches and hands each dispatched instruction its speculative branch mask.
- Tracks the dependency masks between tags.
- Arbitrates branch resolutions from the execution units and drives the single clean/kill broadcast bus.

Parameters:
- NUM_TAGS, 4, number of branch tags (width of branch_mask).
- TAG_WIDTH, $clog2(NUM_TAGS), width of a tag index.
- NUM_RES, 2, number of resolution requesters (branch execution units).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- alloc_req  in  1  dispatch wants a tag for a new branch this cycle.
- alloc_gnt  out  1  tag granted this cycle.
- alloc_tag  out  TAG_WIDTH  granted tag index.
- alloc_mask  out  NUM_TAGS  speculative mask for the dispatching instruction (live tags, excluding any tag being broadcast).
- tags_full  out  1  no allocatable tag.
- res_valid  in  NUM_RES  resolution request per unit.
- res_tag  in  NUM_RES*TAG_WIDTH  tag being resolved, per unit.
- res_mispredict  in  NUM_RES  1 = kill, 0 = clean.
- res_ready  out  NUM_RES  request consumed this cycle.
- flush  in  1  global pipeline flush.
- brb_broadcast  out  1  broadcast valid.
- brb_tag  out  TAG_WIDTH  broadcast tag.
- brb_clean  out  1  clean (correct prediction).
- brb_kill  out  1  kill (misprediction).

Behaviour:
- State:
  - live[NUM_TAGS] bitmap.
  - dep[t][NUM_TAGS]: live mask captured when tag t was allocated.
  - Registered broadcast outputs.
  - Round-robin pointer rr[$clog2(NUM_RES)].
- Reset (rst low, async): live=0, dep=0, rr=0. All brb_* outputs=0, res_ready=0, alloc_gnt=0, tags_full=0.
- Allocation (combinational grant, state update at clock edge):
  - Candidate = lowest index t with live[t]=0 and not (brb_broadcast and t==brb_tag).
  - alloc_gnt = alloc_req & candidate exists & ~brb_kill & ~flush.
  - alloc_mask = live with bit brb_tag cleared when brb_broadcast. Driven every cycle.
  - On grant: live[t]<=1, dep[t]<=alloc_mask.
  - tags_full = no candidate exists.
- Resolution arbitration:
  - Requests are eligible only when ~brb_kill & ~flush.
  - Round-robin over eligible res_valid, starting at rr. One grant per cycle.
  - res_ready is one-hot on the granted unit. rr <= granted+1 (mod NUM_RES).
  - If the granted tag is not live, the request is consumed and no broadcast follows.
  - A request is never granted for the tag currently on brb_tag; it waits.
- Broadcast, 1-cycle latency:
  - A grant in cycle N produces brb_broadcast=1 in cycle N+1, with brb_tag and exactly one of brb_clean/brb_kill.
  - Otherwise brb_broadcast=0, brb_clean=0, brb_kill=0.
- Bookkeeping at the end of the broadcast cycle N+1:
  - clean k: live[k]<=0; bit k cleared in every dep[j].
  - kill k: live[k]<=0, and live[j]<=0 for every j with dep[j][k]=1. Freed entries have dep cleared.
- The tag on the bus is never reallocated during its broadcast cycle.
- Simultaneous allocation and clean in the same cycle: both apply. The new dep excludes the cleaned bit.
- flush: live<=0, dep<=0, and the pending broadcast is suppressed (brb_* = 0 next cycle). rr is unchanged.
- Reset asserted mid-broadcast drops the broadcast immediately (async).

Test Plan:
- Reset, then 4 alloc_req cycles -> alloc_tag 0,1,2,3; alloc_mask 0000,0001,0011,0111; tags_full=1 after the 4th; a 5th request gets alloc_gnt=0.
- Tags 0..2 live; unit0 resolves tag1 clean -> next cycle brb_broadcast=1, brb_tag=1, brb_clean=1; then live=0101; dep[2]=0001; an alloc in the broadcast cycle gets tag 3 (not 1) with alloc_mask 0101.
- Tags 0..3 live in order; kill tag1 -> brb_kill=1, tag=1; alloc_gnt=0 and res_ready=00 in that cycle; afterwards live=0001.
- Both units valid every cycle (tags 2 and 3, clean) -> res_ready alternates 01,10; broadcasts tag2 then tag3 on consecutive cycles.
- Resolve non-live tag 2 -> res_ready pulses, no broadcast, live unchanged.
- Grant in cycle N with flush=1 in N -> no broadcast in N+1; live=0; first alloc after flush gets tag 0 with mask 0000.

Source files
------------

// File: rtl/branch_tag_ctrl.sv
// Branch-tag allocator and resolution arbiter: hands out one-hot speculation tags, tracks
// inter-tag dependencies and drives the single registered clean/kill broadcast bus.
module branch_tag_ctrl #(
    parameter int unsigned NUM_TAGS  = 4,
    parameter int unsigned TAG_WIDTH = $clog2(NUM_TAGS),
    parameter int unsigned NUM_RES   = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         alloc_req_i,
    output logic                         alloc_gnt_o,
    output logic [TAG_WIDTH-1:0]         alloc_tag_o,
    output logic [NUM_TAGS-1:0]          alloc_mask_o,
    output logic                         tags_full_o,
    input  logic [NUM_RES-1:0]           res_valid_i,
    input  logic [NUM_RES*TAG_WIDTH-1:0] res_tag_i,
    input  logic [NUM_RES-1:0]           res_mispredict_i,
    output logic [NUM_RES-1:0]           res_ready_o,
    input  logic                         flush_i,
    output logic                         brb_broadcast_o,
    output logic [TAG_WIDTH-1:0]         brb_tag_o,
    output logic                         brb_clean_o,
    output logic                         brb_kill_o
);
    localparam int unsigned RrW = (NUM_RES > 1) ? $clog2(NUM_RES) : 1;

    logic [NUM_TAGS-1:0]  live_q, live_d;
    logic [NUM_TAGS-1:0]  dep_q [NUM_TAGS];
    logic [NUM_TAGS-1:0]  dep_d [NUM_TAGS];
    logic [RrW-1:0]       rr_q, rr_d;
    logic                 bv_q, bv_d, bkill_q, bkill_d;
    logic [TAG_WIDTH-1:0] btag_q, btag_d;

    logic [TAG_WIDTH-1:0] res_tags [NUM_RES];
    logic [NUM_TAGS-1:0]  bus_onehot;
    logic                 cand_found;
    logic [TAG_WIDTH-1:0] cand_idx;
    logic                 stall;
    logic                 res_gnt, res_sel_mis;
    logic [RrW-1:0]       res_idx, cur;
    logic [TAG_WIDTH-1:0] res_sel_tag;

    for (genvar g = 0; g < NUM_RES; g++) begin : g_unpack
        assign res_tags[g] = res_tag_i[g*TAG_WIDTH +: TAG_WIDTH];
    end

    always_comb begin
        bus_onehot = '0;
        if (bv_q) bus_onehot[btag_q] = 1'b1;
    end

    // The tag on the bus is still busy this cycle, so it is never a candidate.
    always_comb begin
        cand_found = 1'b0;
        cand_idx   = '0;
        for (int unsigned t = 0; t < NUM_TAGS; t++) begin
            if (!cand_found && !live_q[t] && !bus_onehot[t]) begin
                cand_found = 1'b1;
                cand_idx   = TAG_WIDTH'(t);
            end
        end
    end

    assign stall        = bkill_q | flush_i | ~rst_ni;
    assign alloc_gnt_o  = alloc_req_i & cand_found & ~stall;
    assign alloc_tag_o  = cand_idx;
    assign alloc_mask_o = live_q & ~bus_onehot;
    assign tags_full_o  = ~cand_found;

    always_comb begin
        res_gnt     = 1'b0;
        res_idx     = '0;
        res_sel_tag = '0;
        res_sel_mis = 1'b0;
        res_ready_o = '0;
        cur         = '0;
        for (int unsigned i = 0; i < NUM_RES; i++) begin
            cur = RrW'((32'(rr_q) + i) % NUM_RES);
            if (!res_gnt && !stall && res_valid_i[cur] && !(bv_q && res_tags[cur] == btag_q)) begin
                res_gnt     = 1'b1;
                res_idx     = cur;
                res_sel_tag = res_tags[cur];
                res_sel_mis = res_mispredict_i[cur];
            end
        end
        if (res_gnt) res_ready_o[res_idx] = 1'b1;
    end

    always_comb begin
        live_d  = live_q;
        dep_d   = dep_q;
        rr_d    = rr_q;
        bv_d    = 1'b0;
        bkill_d = 1'b0;
        btag_d  = btag_q;
        if (bv_q) begin
            if (bkill_q) begin
                for (int unsigned j = 0; j < NUM_TAGS; j++) begin
                    if (bus_onehot[j] || dep_q[j][btag_q]) begin
                        live_d[j] = 1'b0;
                        dep_d[j]  = '0;
                    end
                end
            end else begin
                live_d[btag_q] = 1'b0;
                for (int unsigned j = 0; j < NUM_TAGS; j++) dep_d[j][btag_q] = 1'b0;
            end
        end
        if (alloc_gnt_o) begin
            live_d[cand_idx] = 1'b1;
            dep_d[cand_idx]  = alloc_mask_o;
        end
        if (res_gnt) begin
            rr_d = (res_idx == RrW'(NUM_RES - 1)) ? '0 : res_idx + 1'b1;
            // A request for a tag that is not live is consumed silently.
            if (live_q[res_sel_tag]) begin
                bv_d    = 1'b1;
                btag_d  = res_sel_tag;
                bkill_d = res_sel_mis;
            end
        end
        if (flush_i) begin
            live_d = '0;
            for (int unsigned j = 0; j < NUM_TAGS; j++) dep_d[j] = '0;
            bv_d    = 1'b0;
            bkill_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            live_q  <= '0;
            for (int unsigned j = 0; j < NUM_TAGS; j++) dep_q[j] <= '0;
            rr_q    <= '0;
            bv_q    <= 1'b0;
            bkill_q <= 1'b0;
            btag_q  <= '0;
        end else begin
            live_q  <= live_d;
            dep_q   <= dep_d;
            rr_q    <= rr_d;
            bv_q    <= bv_d;
            bkill_q <= bkill_d;
            btag_q  <= btag_d;
        end
    end

    assign brb_broadcast_o = bv_q;
    assign brb_tag_o       = btag_q;
    assign brb_clean_o     = bv_q & ~bkill_q;
    assign brb_kill_o      = bv_q & bkill_q;

endmodule

// File: tb/tb_branch_tag_ctrl.sv
// Directed scenarios plus randomized traffic checked against a set-based model of the
// branch-tag rules (live set, per-tag dependency sets, pending broadcast).
module tb_branch_tag_ctrl;
    localparam int NT = 4;
    localparam int TW = 2;
    localparam int NR = 2;

    logic          clk = 1'b0, rst_n = 1'b1;
    logic          alloc_req = 1'b0, flush = 1'b0;
    logic          alloc_gnt, tags_full;
    logic [TW-1:0] alloc_tag, brb_tag;
    logic [NT-1:0] alloc_mask;
    logic [NR-1:0] res_valid = '0, res_mispredict = '0, res_ready;
    logic [NR*TW-1:0] res_tag = '0;
    logic          brb_broadcast, brb_clean, brb_kill;

    int errors = 0;
    int checks = 0;

    // Model state
    bit m_live[NT];
    bit m_dep[NT][NT];
    bit m_bv, m_bkill;
    int m_btag, m_rr;

    branch_tag_ctrl #(.NUM_TAGS(NT), .TAG_WIDTH(TW), .NUM_RES(NR)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .alloc_req_i(alloc_req), .alloc_gnt_o(alloc_gnt), .alloc_tag_o(alloc_tag),
        .alloc_mask_o(alloc_mask), .tags_full_o(tags_full),
        .res_valid_i(res_valid), .res_tag_i(res_tag), .res_mispredict_i(res_mispredict),
        .res_ready_o(res_ready), .flush_i(flush),
        .brb_broadcast_o(brb_broadcast), .brb_tag_o(brb_tag),
        .brb_clean_o(brb_clean), .brb_kill_o(brb_kill)
    );

    always #5 clk = ~clk;

    function automatic int unit_tag(input int u);
        return int'(res_tag[u*TW +: TW]);
    endfunction

    function automatic int m_cand();
        for (int t = 0; t < NT; t++)
            if (!m_live[t] && !(m_bv && t == m_btag)) return t;
        return -1;
    endfunction

    function automatic logic [NT-1:0] m_mask();
        logic [NT-1:0] m;
        for (int t = 0; t < NT; t++) m[t] = m_live[t] && !(m_bv && t == m_btag);
        return m;
    endfunction

    function automatic int m_winner();
        int u;
        if ((m_bv && m_bkill) || flush) return -1;
        for (int k = 0; k < NR; k++) begin
            u = (m_rr + k) % NR;
            if (res_valid[u] && !(m_bv && unit_tag(u) == m_btag)) return u;
        end
        return -1;
    endfunction

    task automatic m_clear();
        for (int j = 0; j < NT; j++) begin
            m_live[j] = 0;
            for (int i = 0; i < NT; i++) m_dep[j][i] = 0;
        end
        m_bv = 0;
        m_bkill = 0;
    endtask

    task automatic m_step(input int cand, input bit gnt, input logic [NT-1:0] mask, input int win);
        bit nbv, nkill;
        int ntag;
        nbv = 0; nkill = 0; ntag = m_btag;
        if (win >= 0) begin
            m_rr = (win + 1) % NR;
            ntag = unit_tag(win);
            if (m_live[ntag]) begin nbv = 1; nkill = res_mispredict[win]; end
        end
        if (m_bv && m_bkill) begin
            for (int j = 0; j < NT; j++)
                if (j == m_btag || m_dep[j][m_btag]) begin
                    m_live[j] = 0;
                    for (int i = 0; i < NT; i++) m_dep[j][i] = 0;
                end
        end else if (m_bv) begin
            m_live[m_btag] = 0;
            for (int j = 0; j < NT; j++) m_dep[j][m_btag] = 0;
        end
        if (gnt) begin
            m_live[cand] = 1;
            for (int i = 0; i < NT; i++) m_dep[cand][i] = mask[i];
        end
        m_bv = nbv; m_bkill = nkill; m_btag = ntag;
        if (flush) m_clear();
    endtask

    task automatic do_reset();
        alloc_req = 0; res_valid = '0; res_tag = '0; res_mispredict = '0; flush = 0;
        rst_n = 0;
        m_clear();
        m_rr = 0; m_btag = 0;
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic alloc_n(input int n);
        alloc_req = 1;
        repeat (n) tick();
        alloc_req = 0;
    endtask

    task automatic test_reset();
        #2 rst_n = 0;
        alloc_req = 1; res_valid = 2'b11;
        #1;
        checks++; if (alloc_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt got=%b exp=0", alloc_gnt); end
        checks++; if (res_ready !== 2'b00) begin errors++; $display("FAIL reset_ready got=%b exp=00", res_ready); end
        checks++; if ({brb_broadcast, brb_clean, brb_kill} !== 3'b000) begin errors++;
            $display("FAIL reset_brb got=%b exp=000", {brb_broadcast, brb_clean, brb_kill}); end
        checks++; if (tags_full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", tags_full); end
        checks++; if (alloc_mask !== 4'b0000) begin errors++; $display("FAIL reset_mask got=%b exp=0000", alloc_mask); end
        alloc_req = 0; res_valid = '0;
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_alloc();
        do_reset();
        alloc_req = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (alloc_gnt !== 1'b1 || alloc_tag !== TW'(i)) begin errors++;
                $display("FAIL alloc_tag%0d got gnt=%b tag=%0d exp gnt=1 tag=%0d", i, alloc_gnt, alloc_tag, i); end
            checks++; if (alloc_mask !== NT'((1 << i) - 1)) begin errors++;
                $display("FAIL alloc_mask%0d got=%b exp=%b", i, alloc_mask, NT'((1 << i) - 1)); end
            tick();
        end
        #1;
        checks++; if (tags_full !== 1'b1) begin errors++; $display("FAIL alloc_full got=%b exp=1", tags_full); end
        checks++; if (alloc_gnt !== 1'b0) begin errors++; $display("FAIL alloc_fifth got=%b exp=0", alloc_gnt); end
        alloc_req = 0;
    endtask

    task automatic test_clean();
        do_reset();
        alloc_n(3);
        res_valid = 2'b01; res_tag = {2'd0, 2'd1}; res_mispredict = 2'b00;
        #1;
        checks++; if (res_ready !== 2'b01) begin errors++; $display("FAIL clean_ready got=%b exp=01", res_ready); end
        tick();
        res_valid = '0; alloc_req = 1;
        #1;
        checks++; if ({brb_broadcast, brb_clean, brb_kill} !== 3'b110 || brb_tag !== 2'd1) begin errors++;
            $display("FAIL clean_bus got bv/cl/kl=%b tag=%0d exp=110 tag=1", {brb_broadcast, brb_clean, brb_kill}, brb_tag); end
        checks++; if (alloc_gnt !== 1'b1 || alloc_tag !== 2'd3 || alloc_mask !== 4'b0101) begin errors++;
            $display("FAIL clean_alloc got gnt=%b tag=%0d mask=%b exp 1/3/0101", alloc_gnt, alloc_tag, alloc_mask); end
        tick();
        #1;
        checks++; if (alloc_gnt !== 1'b1 || alloc_tag !== 2'd1 || alloc_mask !== 4'b1101) begin errors++;
            $display("FAIL clean_realloc got gnt=%b tag=%0d mask=%b exp 1/1/1101", alloc_gnt, alloc_tag, alloc_mask); end
        tick();
        alloc_req = 0;
        // Tag 1 depends on 3; tag 2 was allocated before 3 and must survive.
        res_valid = 2'b01; res_tag = {2'd0, 2'd3}; res_mispredict = 2'b01;
        tick();
        res_valid = '0; res_mispredict = '0;
        #1;
        checks++; if (brb_kill !== 1'b1 || brb_tag !== 2'd3) begin errors++;
            $display("FAIL dep_kill got kill=%b tag=%0d exp kill=1 tag=3", brb_kill, brb_tag); end
        tick();
        #1;
        checks++; if (alloc_mask !== 4'b0101) begin errors++; $display("FAIL dep_live got=%b exp=0101", alloc_mask); end
    endtask

    task automatic test_kill();
        do_reset();
        alloc_n(4);
        res_valid = 2'b01; res_tag = {2'd0, 2'd1}; res_mispredict = 2'b01;
        #1;
        checks++; if (res_ready !== 2'b01) begin errors++; $display("FAIL kill_ready got=%b exp=01", res_ready); end
        tick();
        res_valid = 2'b10; res_tag = {2'd3, 2'd0}; res_mispredict = '0; alloc_req = 1;
        #1;
        checks++; if ({brb_broadcast, brb_clean, brb_kill} !== 3'b101 || brb_tag !== 2'd1) begin errors++;
            $display("FAIL kill_bus got bv/cl/kl=%b tag=%0d exp=101 tag=1", {brb_broadcast, brb_clean, brb_kill}, brb_tag); end
        checks++; if (alloc_gnt !== 1'b0 || res_ready !== 2'b00) begin errors++;
            $display("FAIL kill_block got gnt=%b ready=%b exp 0/00", alloc_gnt, res_ready); end
        tick();
        res_valid = '0; alloc_req = 0;
        #1;
        checks++; if (alloc_mask !== 4'b0001) begin errors++; $display("FAIL kill_live got=%b exp=0001", alloc_mask); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        alloc_n(4);
        res_valid = 2'b11; res_tag = {2'd3, 2'd2}; res_mispredict = '0;
        #1;
        checks++; if (res_ready !== 2'b01) begin errors++; $display("FAIL b2b_ready0 got=%b exp=01", res_ready); end
        tick();
        res_valid = 2'b10;
        #1;
        checks++; if (res_ready !== 2'b10) begin errors++; $display("FAIL b2b_ready1 got=%b exp=10", res_ready); end
        checks++; if (brb_broadcast !== 1'b1 || brb_clean !== 1'b1 || brb_tag !== 2'd2) begin errors++;
            $display("FAIL b2b_bus0 got bv=%b cl=%b tag=%0d exp 1/1/2", brb_broadcast, brb_clean, brb_tag); end
        tick();
        res_valid = '0;
        #1;
        checks++; if (brb_broadcast !== 1'b1 || brb_clean !== 1'b1 || brb_tag !== 2'd3) begin errors++;
            $display("FAIL b2b_bus1 got bv=%b cl=%b tag=%0d exp 1/1/3", brb_broadcast, brb_clean, brb_tag); end
        tick();
        #1;
        checks++; if (brb_broadcast !== 1'b0 || alloc_mask !== 4'b0011) begin errors++;
            $display("FAIL b2b_end got bv=%b mask=%b exp 0/0011", brb_broadcast, alloc_mask); end
    endtask

    task automatic test_nonlive();
        do_reset();
        alloc_n(2);
        res_valid = 2'b01; res_tag = {2'd0, 2'd2}; res_mispredict = '0;
        #1;
        checks++; if (res_ready !== 2'b01) begin errors++; $display("FAIL nonlive_ready got=%b exp=01", res_ready); end
        tick();
        res_valid = '0;
        #1;
        checks++; if (brb_broadcast !== 1'b0 || alloc_mask !== 4'b0011) begin errors++;
            $display("FAIL nonlive_after got bv=%b mask=%b exp 0/0011", brb_broadcast, alloc_mask); end
    endtask

    task automatic test_flush();
        do_reset();
        alloc_n(3);
        res_valid = 2'b01; res_tag = {2'd0, 2'd0}; flush = 1; alloc_req = 1;
        #1;
        checks++; if (res_ready !== 2'b00 || alloc_gnt !== 1'b0) begin errors++;
            $display("FAIL flush_block got ready=%b gnt=%b exp 00/0", res_ready, alloc_gnt); end
        tick();
        flush = 0; res_valid = '0;
        #1;
        checks++; if (brb_broadcast !== 1'b0) begin errors++; $display("FAIL flush_bus got=%b exp=0", brb_broadcast); end
        checks++; if (alloc_gnt !== 1'b1 || alloc_tag !== 2'd0 || alloc_mask !== 4'b0000) begin errors++;
            $display("FAIL flush_alloc got gnt=%b tag=%0d mask=%b exp 1/0/0000", alloc_gnt, alloc_tag, alloc_mask); end
        tick();
        alloc_req = 0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        alloc_n(1);
        res_valid = 2'b01; res_tag = '0; res_mispredict = '0;
        @(posedge clk);
        #1 res_valid = '0;
        checks++; if (brb_broadcast !== 1'b1) begin errors++; $display("FAIL mid_pre got=%b exp=1", brb_broadcast); end
        #1 rst_n = 0;
        #1;
        checks++; if (brb_broadcast !== 1'b0 || brb_clean !== 1'b0) begin errors++;
            $display("FAIL mid_drop got bv=%b cl=%b exp 0/0", brb_broadcast, brb_clean); end
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_random();
        int cand, win;
        bit gnt;
        logic [NT-1:0] mask;
        logic [NR-1:0] rdy;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            alloc_req = 1'($urandom_range(0, 1));
            res_valid = NR'($urandom_range(0, 3));
            res_tag = (NR*TW)'($urandom_range(0, 15));
            res_mispredict = {1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0)};
            flush = ($urandom_range(0, 31) == 0);
            #1;
            cand = m_cand();
            gnt = alloc_req && cand >= 0 && !(m_bv && m_bkill) && !flush;
            mask = m_mask();
            win = m_winner();
            rdy = (win >= 0) ? NR'(1 << win) : '0;
            checks++; if (alloc_gnt !== gnt) begin errors++; $display("FAIL rnd_gnt c=%0d got=%b exp=%b", c, alloc_gnt, gnt); end
            checks++; if (alloc_mask !== mask) begin errors++; $display("FAIL rnd_mask c=%0d got=%b exp=%b", c, alloc_mask, mask); end
            checks++; if (tags_full !== (cand < 0)) begin errors++; $display("FAIL rnd_full c=%0d got=%b exp=%b", c, tags_full, cand < 0); end
            if (cand >= 0) begin
                checks++; if (alloc_tag !== TW'(cand)) begin errors++; $display("FAIL rnd_tag c=%0d got=%0d exp=%0d", c, alloc_tag, cand); end
            end
            checks++; if (res_ready !== rdy) begin errors++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, res_ready, rdy); end
            checks++; if ({brb_broadcast, brb_clean, brb_kill} !== {m_bv, m_bv && !m_bkill, m_bv && m_bkill}) begin errors++;
                $display("FAIL rnd_bus c=%0d got=%b exp=%b", c, {brb_broadcast, brb_clean, brb_kill},
                         {m_bv, m_bv && !m_bkill, m_bv && m_bkill}); end
            if (m_bv) begin
                checks++; if (brb_tag !== TW'(m_btag)) begin errors++; $display("FAIL rnd_btag c=%0d got=%0d exp=%0d", c, brb_tag, m_btag); end
            end
            m_step(cand, gnt, mask, win);
            tick();
        end
        alloc_req = 0; res_valid = '0; flush = 0;
    endtask

    initial begin
        test_reset();
        test_alloc();
        test_clean();
        test_kill();
        test_back_to_back();
        test_nonlive();
        test_flush();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
